// File: rtl/pool_window_buffer.sv
// rtl/pool_window_buffer.sv - raster line buffer emitting non-overlapping 2x2 windows
module pool_window_buffer #(
    parameter int WORD_SIZE  = 16,
    parameter int IMG_WIDTH  = 24,
    parameter int IMG_HEIGHT = 24
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WORD_SIZE-1:0] in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WORD_SIZE-1:0] out_a0,
    output logic [WORD_SIZE-1:0] out_a1,
    output logic [WORD_SIZE-1:0] out_b0,
    output logic [WORD_SIZE-1:0] out_b1,
    output logic                 frame_done
);

    localparam int CW = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
    localparam int RW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
    localparam logic [CW-1:0] COL_MAX = CW'(IMG_WIDTH - 1);
    localparam logic [RW-1:0] ROW_MAX = RW'(IMG_HEIGHT - 1);
    localparam logic [CW-1:0] COL_ONE = CW'(1);
    localparam logic [RW-1:0] ROW_ONE = RW'(1);

    // Windows tile the frame exactly, so both dimensions must be even.
    generate
        if ((IMG_WIDTH % 2) != 0) begin : g_bad_width
            $error("pool_window_buffer: IMG_WIDTH must be even");
        end
        if ((IMG_HEIGHT % 2) != 0) begin : g_bad_height
            $error("pool_window_buffer: IMG_HEIGHT must be even");
        end
    endgenerate

    logic [CW-1:0]        col;
    logic [RW-1:0]        row;
    logic [WORD_SIZE-1:0] line_buf [IMG_WIDTH];
    logic [WORD_SIZE-1:0] b0_hold;
    logic                 out_last;
    logic                 accept;
    logic                 win_load;
    logic                 col_last;
    logic                 row_last;

    // One-deep output register: accept whenever it is empty or draining now.
    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;
    assign col_last = (col == COL_MAX);
    assign row_last = (row == ROW_MAX);
    // The odd-row, odd-column pixel is the b1 corner that closes a window.
    assign win_load = accept && row[0] && col[0];

    // Raster position of the next pixel to be accepted.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            col <= '0;
            row <= '0;
        end else if (accept) begin
            if (col_last) begin
                col <= '0;
                row <= row_last ? '0 : row + ROW_ONE;
            end else begin
                col <= col + COL_ONE;
            end
        end
    end

    // Even rows park the top pixels; contents are always rewritten before use.
    always_ff @(posedge clk) begin
        if (accept && !row[0]) begin
            line_buf[col] <= in_data;
        end
    end

    // Bottom-left pixel waits here until its right neighbour arrives.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            b0_hold <= '0;
        end else if (accept && row[0] && !col[0]) begin
            b0_hold <= in_data;
        end
    end

    // Window register: a fresh window overrides the drain so there is no bubble.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_a0    <= '0;
            out_a1    <= '0;
            out_b0    <= '0;
            out_b1    <= '0;
            out_last  <= 1'b0;
        end else if (win_load) begin
            out_valid <= 1'b1;
            out_a0    <= line_buf[col - COL_ONE];
            out_a1    <= line_buf[col];
            out_b0    <= b0_hold;
            out_b1    <= in_data;
            out_last  <= row_last && col_last;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // Pulse once the frame's final window has been handed downstream.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            frame_done <= 1'b0;
        end else begin
            frame_done <= out_valid && out_ready && out_last;
        end
    end

endmodule
